// File: rtl/mem_access_unit.sv
// Data-memory sequencer: turns lb/lw/sb/sw into one or two byte beats on an 8-bit req/ack port.
// Latency: mem_req one cycle after start, done one cycle after the final ack (byte 2, halfword 3 with zero wait).
// Backpressure: beats hold until mem_ack or the per-beat timeout expires; start is dropped while busy.
module mem_access_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wmem,
    input  logic              memc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

    logic [1:0]       state;
    logic             memc_q;
    logic [7:0]       wdata_hi;
    logic [7:0]       b0_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             tmo;

    // Ack has priority: a timeout only fires on a cycle with no ack.
    assign tmo = (TIMEOUT != 0) && (wait_cnt == TMAX) && !mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            memc_q    <= 1'b0;
            wdata_hi  <= 8'h00;
            b0_q      <= 8'h00;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 16'h0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= BEAT0;
                        memc_q    <= memc;
                        wdata_hi  <= wdata[15:8];
                        wait_cnt  <= '0;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= wmem;
                        mem_addr  <= addr;
                        mem_wdata <= wdata[7:0];
                    end
                end
                BEAT0: begin
                    if (mem_ack) begin
                        b0_q <= mem_rdata;
                        if (memc_q) begin
                            state     <= BEAT1;
                            wait_cnt  <= '0;
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            mem_wdata <= wdata_hi;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            mem_req <= 1'b0;
                            done    <= 1'b1;
                            if (!mem_we)
                                rdata <= {{8{mem_rdata[7]}}, mem_rdata};
                        end
                    end else if (tmo) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                BEAT1: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (!mem_we)
                            rdata <= {mem_rdata, b0_q};
                    end else if (tmo) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of accesses against a byte-memory responder, plus reset/back-to-back sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, wmem, memc;
    logic [15:0] addr, wdata;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wmem(wmem), .memc(memc),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        w;
        logic        c;
        logic [15:0] a;
        logic [15:0] wd;
        int          waits;
        bit          pre;
        logic [7:0]  p0;
        logic [7:0]  p1;
        bit          chain;
        int          spam;
        bit          exp_err;
        int          exp_cyc;
        logic [15:0] exp_rd;
        int          exp_beats;
        logic [15:0] exp_a1;
        logic [7:0]  exp_wd0;
        logic [7:0]  exp_wd1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] b_addr [4];
    logic        b_we   [4];
    logic [7:0]  b_wd   [4];
    int          beats, cyc;
    logic        got_done, got_err, busy1, busy_end, mreq_end;

    localparam int NV = 11;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic c, input logic [15:0] a, input logic [15:0] wd,
                                input int waits, input bit pre, input logic [7:0] p0, input logic [7:0] p1,
                                input bit chain, input int spam, input bit exp_err, input int exp_cyc,
                                input logic [15:0] exp_rd, input int exp_beats, input logic [15:0] exp_a1,
                                input logic [7:0] exp_wd0, input logic [7:0] exp_wd1);
        vec_t v;
        v.w = w; v.c = c; v.a = a; v.wd = wd; v.waits = waits; v.pre = pre; v.p0 = p0; v.p1 = p1;
        v.chain = chain; v.spam = spam; v.exp_err = exp_err; v.exp_cyc = exp_cyc; v.exp_rd = exp_rd;
        v.exp_beats = exp_beats; v.exp_a1 = exp_a1; v.exp_wd0 = exp_wd0; v.exp_wd1 = exp_wd1;
        return v;
    endfunction

    // Issues one access and plays the memory side: ack after v.waits idle cycles per beat (-1 = never).
    task automatic run_access(input vec_t v);
        int wc;
        if (!v.chain) @(negedge clk);
        if (v.pre) begin
            mem[v.a]         = v.p0;
            mem[v.a + 16'd1] = v.p1;
        end
        start = 1'b1; wmem = v.w; memc = v.c; addr = v.a; wdata = v.wd;
        cyc = 0; beats = 0; wc = 0; got_done = 1'b0; got_err = 1'b0;
        busy1 = 1'b0; busy_end = 1'b1; mreq_end = 1'b1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (cyc <= v.spam) begin
                start = 1'b1; wmem = ~v.w; memc = ~v.c; addr = 16'h5555; wdata = 16'h0000;
            end else begin
                start = 1'b0;
            end
            if (cyc == 1) busy1 = busy;
            if (done || err) begin
                got_done = done; got_err = err; busy_end = busy; mreq_end = mem_req;
                break;
            end
            if (mem_req) begin
                if (wc == v.waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (beats < 4) begin
                        b_addr[beats] = mem_addr;
                        b_we[beats]   = mem_we;
                        b_wd[beats]   = mem_wdata;
                    end
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    beats++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, " done"}, {31'd0, got_done}, {31'd0, !v.exp_err});
        check({tag, " err"}, {31'd0, got_err}, {31'd0, v.exp_err});
        check({tag, " cycles"}, cyc, v.exp_cyc);
        check({tag, " rdata"}, {16'd0, rdata}, {16'd0, v.exp_rd});
        check({tag, " busy_c1"}, {31'd0, busy1}, 32'd1);
        check({tag, " busy_end"}, {31'd0, busy_end}, 32'd0);
        check({tag, " req_end"}, {31'd0, mreq_end}, 32'd0);
        check({tag, " beats"}, beats, v.exp_beats);
        if (v.exp_beats >= 1) begin
            check({tag, " addr0"}, {16'd0, b_addr[0]}, {16'd0, v.a});
            check({tag, " we0"}, {31'd0, b_we[0]}, {31'd0, v.w});
            if (v.w) check({tag, " wd0"}, {24'd0, b_wd[0]}, {24'd0, v.exp_wd0});
        end
        if (v.exp_beats >= 2) begin
            check({tag, " addr1"}, {16'd0, b_addr[1]}, {16'd0, v.exp_a1});
            check({tag, " we1"}, {31'd0, b_we[1]}, {31'd0, v.w});
            if (v.w) check({tag, " wd1"}, {24'd0, b_wd[1]}, {24'd0, v.exp_wd1});
        end
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst_n = 1'b0; start = 1'b0; wmem = 1'b0; memc = 1'b0; addr = 16'h0; wdata = 16'h0;
        mem_ack = 1'b0; mem_rdata = 8'h00;

        //        w     c     addr      wdata     wt  pre p0     p1     ch sp er cyc rdata     bt a1        wd0    wd1
        vt[0]  = mk(1'b0, 1'b0, 16'h0010, 16'h0000, 0,  1, 8'h80, 8'h00, 0, 0, 0, 2,  16'hFF80, 1, 16'h0011, 8'h00, 8'h00);
        vt[1]  = mk(1'b0, 1'b0, 16'h0011, 16'h0000, 1,  1, 8'h7F, 8'h00, 0, 0, 0, 3,  16'h007F, 1, 16'h0012, 8'h00, 8'h00);
        vt[2]  = mk(1'b1, 1'b1, 16'h0021, 16'hBEEF, 2,  0, 8'h00, 8'h00, 0, 0, 0, 7,  16'h007F, 2, 16'h0022, 8'hEF, 8'hBE);
        vt[3]  = mk(1'b0, 1'b1, 16'hFFFF, 16'h0000, 0,  1, 8'h34, 8'h12, 0, 0, 0, 3,  16'h1234, 2, 16'h0000, 8'h00, 8'h00);
        vt[4]  = mk(1'b0, 1'b1, 16'h0021, 16'h0000, 0,  0, 8'h00, 8'h00, 0, 0, 0, 3,  16'hBEEF, 2, 16'h0022, 8'h00, 8'h00);
        vt[5]  = mk(1'b0, 1'b1, 16'h0200, 16'h0000, 3,  1, 8'hCD, 8'hAB, 0, 0, 0, 9,  16'hABCD, 2, 16'h0201, 8'h00, 8'h00);
        vt[6]  = mk(1'b0, 1'b1, 16'h0030, 16'h0000, 1,  1, 8'h11, 8'h22, 0, 3, 0, 5,  16'h2211, 2, 16'h0031, 8'h00, 8'h00);
        vt[7]  = mk(1'b0, 1'b0, 16'h0010, 16'h0000, 0,  0, 8'h00, 8'h00, 0, 0, 0, 2,  16'hFF80, 1, 16'h0011, 8'h00, 8'h00);
        vt[8]  = mk(1'b1, 1'b0, 16'h0100, 16'h1255, 0,  0, 8'h00, 8'h00, 1, 0, 0, 2,  16'hFF80, 1, 16'h0101, 8'h55, 8'h00);
        vt[9]  = mk(1'b0, 1'b0, 16'h0100, 16'h0000, 0,  0, 8'h00, 8'h00, 0, 0, 0, 2,  16'h0055, 1, 16'h0101, 8'h00, 8'h00);
        vt[10] = mk(1'b1, 1'b0, 16'h0300, 16'h00AA, -1, 0, 8'h00, 8'h00, 0, 0, 1, 17, 16'h0055, 0, 16'h0301, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        check("rst rdata", {16'd0, rdata}, 32'd0);
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst mem_wdata", {24'd0, mem_wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_access(vt[i]);
            check_result($sformatf("v%0d", i), vt[i]);
            if (!(i + 1 < NV && vt[i + 1].chain)) begin
                @(negedge clk);
                check($sformatf("v%0d single_pulse", i), {30'd0, done, err}, 32'd0);
                check($sformatf("v%0d idle_after", i), {30'd0, busy, mem_req}, 32'd0);
            end
        end

        // Reset during the second beat of a halfword store leaves only the low byte written.
        @(negedge clk);
        start = 1'b1; wmem = 1'b1; memc = 1'b1; addr = 16'h0400; wdata = 16'hA55A;
        @(negedge clk);
        start = 1'b0;
        check("rstmid beat0 req", {31'd0, mem_req}, 32'd1);
        check("rstmid beat0 wd", {24'd0, mem_wdata}, 32'h5A);
        mem_ack = 1'b1; mem_rdata = 8'h00;
        mem[mem_addr] = mem_wdata;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rstmid beat1 addr", {16'd0, mem_addr}, 32'h0401);
        check("rstmid beat1 busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid async req", {31'd0, mem_req}, 32'd0);
        check("rstmid async busy", {31'd0, busy}, 32'd0);
        check("rstmid async rdata", {16'd0, rdata}, 32'd0);
        check("rstmid async addr", {16'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid idle", {30'd0, busy, mem_req}, 32'd0);

        v = mk(1'b0, 1'b0, 16'h0400, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 2, 16'h005A, 1, 16'h0401, 8'h00, 8'h00);
        run_access(v);
        check_result("post_rst lb", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access sequencer that sits directly downstream of the control unit in the 16-bit CPU. It consumes the decoded `wmem`/`memc` controls, the ALU-computed address, and the store data. It turns each lb/lw/sb/sw into one or two byte transactions on an 8-bit req/ack memory port. It returns sign-extended or assembled read data to the register write-back path and raises `busy` so the pipeline can stall.

## Interface
- `ADDR_W`, 16, byte address width.
- `TIMEOUT`, 15, max cycles a beat may wait for `mem_ack` before abort; 0 disables timeout.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe, sampled only in IDLE.
- `wmem`  in  1  0 = load, 1 = store.
- `memc`  in  1  0 = byte (lb/sb), 1 = halfword (lw/sw).
- `addr`  in  ADDR_W  byte address of the access.
- `wdata`  in  16  store data; sb uses `wdata[7:0]`.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the access completes successfully.
- `err`  out  1  one-cycle pulse when the access is aborted by timeout.
- `rdata`  out  16  load result, valid with `done`, held until the next `done`.
- `mem_req`  out  1  byte beat request.
- `mem_we`  out  1  beat is a write.
- `mem_addr`  out  ADDR_W  beat byte address.
- `mem_wdata`  out  8  beat write byte.
- `mem_rdata`  in  8  beat read byte, valid in the cycle `mem_ack` = 1.
- `mem_ack`  in  1  beat completes at the edge where `mem_req` = 1 and `mem_ack` = 1.

## Operation
- States: IDLE, BEAT0, BEAT1.
- IDLE:
  - On `start` = 1, latch `wmem`, `memc`, `addr` and `wdata`, then go to BEAT0.
  - Otherwise remain in IDLE.
- BEAT0:
  - Outputs: `mem_req` = 1, `mem_addr` = latched addr, `mem_we` = latched wmem, `mem_wdata` = wdata[7:0].
  - On ack: capture `mem_rdata` as the low byte.
  - On ack with memc = 0: go to IDLE and pulse `done`.
  - On ack with memc = 1: go to BEAT1.
- BEAT1:
  - Outputs: `mem_req` = 1, `mem_addr` = addr + 1 (mod 2^ADDR_W, so 0xFFFF wraps to 0x0000), `mem_wdata` = wdata[15:8].
  - On ack: capture the high byte, go to IDLE, pulse `done`.
- Byte order is little-endian: low byte at addr, high byte at addr+1. Misaligned halfwords are legal.
- Load result:
  - lb: `rdata` = {8{b0[7]}, b0} (sign-extended).
  - lw: `rdata` = {b1, b0}.
  - Stores leave `rdata` unchanged.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req` = 1 and no ack has been taken.
- `mem_req` drops in the cycle after the final ack.
- Timeout:
  - A per-beat wait counter clears on entry to each beat and increments every cycle without ack.
  - When the counter reaches TIMEOUT and ack is still low: go to IDLE, pulse `err`, no `done`, `rdata` unchanged.
  - If ack and timeout occur in the same cycle, ack wins.
- Inputs other than `mem_ack`/`mem_rdata` are ignored while busy; `start` while busy is dropped, not queued.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `rdata` 0x0000, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, wait counter 0.
- Reset asserted mid-access clears all state and outputs immediately, asynchronously. `mem_req` falls without waiting for ack. A halfword store interrupted between beats leaves a partial write; this is accepted behaviour.
- All outputs are registered; no combinational path from `start`/`mem_ack` to any output.
- Timing with `start` sampled at edge 0 and zero-wait ack:
  - `mem_req` high in cycle 1.
  - Byte access: `done` high in cycle 2.
  - Halfword access: BEAT1 in cycle 2, `done` in cycle 3.
- Each wait cycle on a beat adds one cycle.
- `busy` is high from cycle 1 until the cycle `done`/`err` is high, where it reads 0.
- A `start` in the same cycle as `done` is accepted, so back-to-back accesses have no bubble beyond the state machine.
- With TIMEOUT = N, `err` pulses N+1 cycles after the beat starts if ack never rises.

## Test plan
- **lb, negative byte:** addr 0x0010, mem byte 0x80, ack immediate -> one beat at 0x0010, `mem_we` 0; `done` 2 cycles after start, `rdata` = 0xFF80.
- **sw, misaligned with waits:** addr 0x0021, wdata 0xBEEF, ack after 2 wait cycles per beat -> beat writes 0xEF@0x0021 then 0xBE@0x0022; `done` 7 cycles after start.
- **lw at top of memory:** addr 0xFFFF, bytes 0x34@0xFFFF and 0x12@0x0000 -> second `mem_addr` = 0x0000, `rdata` = 0x1234.
- **Timeout:** TIMEOUT = 15, sb with ack held low -> `err` pulses once 16 cycles after the beat begins, no `done`, `rdata` unchanged, returns to IDLE.
- **Start handling:** `start` pulses during BEAT0 of an lw are ignored (exactly 2 beats issued). A new sb started in the `done` cycle begins BEAT0 on the next cycle.
- **Reset mid-access:** deassert `rst_n` during BEAT1 of sw 0xA55A -> `mem_req`/`busy` go 0 asynchronously. After release, state is IDLE and a fresh lb completes normally.
